// File: rtl/natalius_uart_port.sv
// natalius_uart_port: processor-port UART with a 4-deep TX FIFO and a
// single-byte RX holding register.
//    DATA   @ BASE_ADDR   : write pushes a TX byte, read pops the RX byte
//    STATUS @ BASE_ADDR+1 : {2'b00, tx_busy, tx_full, tx_empty,
//                            rx_frame_err, rx_overrun, rx_valid}
//                           write clears rx_overrun and rx_frame_err
module natalius_uart_port #(
   parameter logic [7:0] BASE_ADDR    = 8'h10,
   parameter int         CLKS_PER_BIT = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] port_addr,
   input  logic       read_e,
   input  logic       write_e,
   input  logic [7:0] din,
   output logic [7:0] dout,
   input  logic       rxd,
   output logic       txd
);

   localparam logic [7:0]  STATUS_ADDR = BASE_ADDR + 8'd1;
   localparam logic [15:0] BIT_LAST    = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_LAST   = 16'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } uart_state_t;

   // ------------------------------------------------------------------
   // Port decode
   // ------------------------------------------------------------------
   logic data_wr;
   logic status_wr;
   logic data_rd;
   logic status_rd;

   assign data_wr   = write_e && (port_addr == BASE_ADDR);
   assign status_wr = write_e && (port_addr == STATUS_ADDR);
   assign data_rd   = read_e  && (port_addr == BASE_ADDR);
   assign status_rd = read_e  && (port_addr == STATUS_ADDR);

   // ------------------------------------------------------------------
   // TX FIFO: 4 entries, 2-bit wrapping pointers, 3-bit occupancy count
   // ------------------------------------------------------------------
   logic [7:0] fifo_mem [4];
   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] fifo_cnt;
   logic       fifo_full;
   logic       fifo_empty;
   logic       fifo_push;
   logic       fifo_pop;

   assign fifo_full  = (fifo_cnt == 3'd4);
   assign fifo_empty = (fifo_cnt == 3'd0);
   assign fifo_push  = data_wr && !fifo_full;

   // Capture pushed bytes into the FIFO storage.
   // NOTE: storage is not reset; occupancy is tracked by fifo_cnt, so stale contents are never read.
   always_ff @(posedge clk) begin
      if (fifo_push) fifo_mem[wr_ptr] <= din;
   end

   // Advance pointers and occupancy; a simultaneous push and pop cancel out.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= 2'd0;
         rd_ptr   <= 2'd0;
         fifo_cnt <= 3'd0;
      end else begin
         if (fifo_push) wr_ptr <= wr_ptr + 2'd1;
         if (fifo_pop)  rd_ptr <= rd_ptr + 2'd1;
         case ({fifo_push, fifo_pop})
            2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
            2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
            default: fifo_cnt <= fifo_cnt;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // TX serialiser
   // ------------------------------------------------------------------
   uart_state_t tx_state;
   logic [15:0] tx_baud;
   logic [2:0]  tx_bit;
   logic [7:0]  tx_shift;
   logic        tx_bit_end;
   logic        tx_busy;

   assign tx_bit_end = (tx_baud == BIT_LAST);
   assign tx_busy    = (tx_state != S_IDLE);
   // A new frame is fetched from IDLE, or straight from the end of STOP so
   // queued bytes go out back-to-back with no idle bit between them.
   assign fifo_pop   = !fifo_empty &&
                       ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end));

   // TX state machine; txd is a registered output so it cannot glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_baud  <= 16'd0;
         tx_bit   <= 3'd0;
         tx_shift <= 8'h00;
         txd      <= 1'b1;
      end else begin
         case (tx_state)
            S_IDLE: begin
               tx_baud <= 16'd0;
               tx_bit  <= 3'd0;
               if (fifo_pop) begin
                  tx_shift <= fifo_mem[rd_ptr];
                  txd      <= 1'b0;
                  tx_state <= S_START;
               end
            end
            S_START: begin
               if (tx_bit_end) begin
                  tx_baud  <= 16'd0;
                  tx_bit   <= 3'd0;
                  txd      <= tx_shift[0];
                  tx_state <= S_DATA;
               end else begin
                  tx_baud <= tx_baud + 16'd1;
               end
            end
            S_DATA: begin
               if (tx_bit_end) begin
                  tx_baud <= 16'd0;
                  if (tx_bit == 3'd7) begin
                     txd      <= 1'b1;
                     tx_state <= S_STOP;
                  end else begin
                     tx_bit   <= tx_bit + 3'd1;
                     tx_shift <= {1'b0, tx_shift[7:1]};
                     txd      <= tx_shift[1];
                  end
               end else begin
                  tx_baud <= tx_baud + 16'd1;
               end
            end
            S_STOP: begin
               if (tx_bit_end) begin
                  tx_baud <= 16'd0;
                  tx_bit  <= 3'd0;
                  if (fifo_pop) begin
                     tx_shift <= fifo_mem[rd_ptr];
                     txd      <= 1'b0;
                     tx_state <= S_START;
                  end else begin
                     tx_state <= S_IDLE;
                  end
               end else begin
                  tx_baud <= tx_baud + 16'd1;
               end
            end
            default: begin
               tx_state <= S_IDLE;
               txd      <= 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // RX synchroniser and deserialiser
   // ------------------------------------------------------------------
   logic rx_meta;
   logic rx_sync;
   logic rx_last;

   // Two-flop synchroniser plus one history flop for falling-edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_last <= 1'b1;
      end else begin
         rx_meta <= rxd;
         rx_sync <= rx_meta;
         rx_last <= rx_sync;
      end
   end

   uart_state_t rx_state;
   logic [15:0] rx_baud;
   logic [2:0]  rx_bit;
   logic [7:0]  rx_shift;
   logic [7:0]  rx_hold;
   logic        rx_valid;
   logic        rx_overrun;
   logic        rx_frame_err;
   logic        rx_bit_end;
   logic        rx_half_end;

   assign rx_bit_end  = (rx_baud == BIT_LAST);
   assign rx_half_end = (rx_baud == HALF_LAST);

   // RX state machine with holding register and sticky status flags.
   // NOTE: processor clears are assigned first and frame-event sets later, so the last non-blocking write (the set) wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state     <= S_IDLE;
         rx_baud      <= 16'd0;
         rx_bit       <= 3'd0;
         rx_shift     <= 8'h00;
         rx_hold      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_overrun   <= 1'b0;
         rx_frame_err <= 1'b0;
      end else begin
         if (data_rd) rx_valid <= 1'b0;
         if (status_wr) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
         end
         case (rx_state)
            S_IDLE: begin
               rx_baud <= 16'd0;
               rx_bit  <= 3'd0;
               if (rx_last && !rx_sync) rx_state <= S_START;
            end
            S_START: begin
               // Mid-start-bit check rejects pulses shorter than half a bit.
               if (rx_half_end) begin
                  rx_baud  <= 16'd0;
                  rx_state <= rx_sync ? S_IDLE : S_DATA;
               end else begin
                  rx_baud <= rx_baud + 16'd1;
               end
            end
            S_DATA: begin
               if (rx_bit_end) begin
                  rx_baud  <= 16'd0;
                  rx_shift <= {rx_sync, rx_shift[7:1]};
                  if (rx_bit == 3'd7) begin
                     rx_state <= S_STOP;
                  end else begin
                     rx_bit <= rx_bit + 3'd1;
                  end
               end else begin
                  rx_baud <= rx_baud + 16'd1;
               end
            end
            S_STOP: begin
               if (rx_bit_end) begin
                  rx_baud  <= 16'd0;
                  rx_bit   <= 3'd0;
                  rx_state <= S_IDLE;
                  if (rx_sync) begin
                     // A DATA read in this same cycle frees the holding register.
                     if (rx_valid && !data_rd) begin
                        rx_overrun <= 1'b1;
                     end else begin
                        rx_hold  <= rx_shift;
                        rx_valid <= 1'b1;
                     end
                  end else begin
                     rx_frame_err <= 1'b1;
                  end
               end else begin
                  rx_baud <= rx_baud + 16'd1;
               end
            end
            default: rx_state <= S_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Read mux
   // ------------------------------------------------------------------
   logic [7:0] status;

   assign status = {2'b00, tx_busy, fifo_full, fifo_empty,
                    rx_frame_err, rx_overrun, rx_valid};

   // Combinational read data; zero whenever no register is being read.
   // NOTE: dout gets a default first so no path through this block infers a latch.
   always_comb begin
      dout = 8'h00;
      if (data_rd) begin
         dout = rx_hold;
      end else if (status_rd) begin
         dout = status;
      end
   end

endmodule

// File: tb/tb_natalius_uart_port.sv
// Testbench for natalius_uart_port: scoreboard of expected read data and
// expected TX bytes, fed by a transaction-level model of the port.
module tb_natalius_uart_port;

   localparam int         CPB  = 16;
   localparam logic [7:0] BASE = 8'h10;
   localparam logic [7:0] STAT = 8'h11;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] port_addr;
   logic       read_e;
   logic       write_e;
   logic [7:0] din;
   logic [7:0] dout;
   logic       rxd;
   logic       txd;

   natalius_uart_port #(
      .BASE_ADDR    (BASE),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .port_addr (port_addr),
      .read_e    (read_e),
      .write_e   (write_e),
      .din       (din),
      .dout      (dout),
      .rxd       (rxd),
      .txd       (txd)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: register-level view of the port
   // ------------------------------------------------------------------
   logic [7:0] m_hold  = 8'h00;
   bit         m_valid = 0;
   bit         m_ovr   = 0;
   bit         m_ferr  = 0;
   bit         m_busy  = 0;   // a frame is on the wire
   int         m_cnt   = 0;   // bytes waiting in the FIFO

   function automatic logic [7:0] m_status();
      return {2'b00, m_busy, (m_cnt == 4), (m_cnt == 0), m_ferr, m_ovr, m_valid};
   endfunction

   // Outcome of a received frame once its stop bit has been judged.
   function automatic void m_rx_done(input logic [7:0] b, input logic stop);
      if (!stop)        m_ferr = 1;
      else if (m_valid) m_ovr  = 1;
      else begin
         m_hold  = b;
         m_valid = 1;
      end
   endfunction

   // ------------------------------------------------------------------
   // Scoreboards
   // ------------------------------------------------------------------
   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] exp;
   } rd_exp_t;

   rd_exp_t     rd_q[$];
   rd_exp_t     mon_e;
   logic [7:0]  tx_exp[$];
   int unsigned start_q[$];

   // Read monitor: compares dout with the oldest queued expectation.
   always @(negedge clk) begin
      if (!rst && read_e) begin
         if (rd_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_unexpected: addr %h dout %h with nothing queued", port_addr, dout);
         end else begin
            mon_e = rd_q.pop_front();
            check($sformatf("read@%h", mon_e.addr), {24'd0, dout}, {24'd0, mon_e.exp});
         end
      end
   end

   // TX monitor: samples each bit at its centre and checks the frame.
   bit         mon_active = 0;
   int         mon_cnt    = 0;
   logic [9:0] mon_bits;
   int         txd_low_cnt = 0;

   always @(negedge clk) begin
      if (txd === 1'b0) txd_low_cnt++;
      if (rst) begin
         mon_active = 0;
      end else if (!mon_active) begin
         if (txd === 1'b0) begin
            mon_active = 1;
            mon_cnt    = 0;
            start_q.push_back(cyc);
         end
      end else begin
         mon_cnt++;
         if (mon_cnt % CPB == CPB / 2) begin
            mon_bits[mon_cnt / CPB] = txd;
            if (mon_cnt / CPB == 9) begin
               mon_active = 0;
               check("tx_start_bit", {31'd0, mon_bits[0]}, 32'd0);
               check("tx_stop_bit",  {31'd0, mon_bits[9]}, 32'd1);
               if (tx_exp.size() == 0) begin
                  n_cmp++;
                  n_bad++;
                  $display("FAIL tx_unexpected: frame %h with nothing queued", mon_bits[8:1]);
               end else begin
                  check("tx_byte", {24'd0, mon_bits[8:1]}, {24'd0, tx_exp.pop_front()});
               end
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus tasks (called at posedge+1, return at posedge+1)
   // ------------------------------------------------------------------
   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic bus_read(input logic [7:0] a);
      rd_exp_t e;
      e.addr = a;
      if (a == BASE) begin
         e.exp   = m_hold;
         m_valid = 0;
      end else if (a == STAT) begin
         e.exp = m_status();
      end else begin
         e.exp = 8'h00;
      end
      rd_q.push_back(e);
      port_addr = a;
      read_e    = 1'b1;
      idle(1);
      read_e    = 1'b0;
   endtask

   task automatic bus_write(input logic [7:0] a, input logic [7:0] d);
      if (a == BASE) begin
         if (m_cnt < 4) begin
            tx_exp.push_back(d);
            if (!m_busy && m_cnt == 0) m_busy = 1;
            else                       m_cnt++;
         end
      end else if (a == STAT) begin
         m_ovr  = 0;
         m_ferr = 0;
      end
      port_addr = a;
      din       = d;
      write_e   = 1'b1;
      idle(1);
      write_e   = 1'b0;
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop);
      rxd = 1'b0;
      idle(CPB);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         idle(CPB);
      end
      rxd = stop;
      idle(CPB);
      rxd = 1'b1;
   endtask

   task automatic wait_tx_drain();
      int t = 0;
      while (tx_exp.size() != 0 && t < 4000) begin
         idle(1);
         t++;
      end
      if (tx_exp.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL tx_drain_timeout: %0d bytes still pending", tx_exp.size());
         tx_exp.delete();
      end
      idle(CPB);
      m_busy = 0;
      m_cnt  = 0;
   endtask

   // Watchdog so the run always ends.
   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Main sequence
   // ------------------------------------------------------------------
   initial begin
      logic [7:0]  r1;
      logic [7:0]  r2;
      logic        stp;
      int          low_cnt;
      int          nk;

      rst       = 1'b1;
      port_addr = 8'h00;
      read_e    = 1'b0;
      write_e   = 1'b0;
      din       = 8'h00;
      rxd       = 1'b1;
      #1;
      check("txd_in_reset", {31'd0, txd}, 32'd1);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(1);

      // Reset state
      bus_read(STAT);
      bus_read(BASE);
      check("txd_idle", {31'd0, txd}, 32'd1);

      // Single byte
      start_q.delete();
      bus_write(BASE, 8'hA5);
      wait_tx_drain();
      check("single_frame_count", start_q.size(), 1);
      bus_read(STAT);

      // FIFO full, discarded sixth write, back-to-back frames
      start_q.delete();
      for (int i = 1; i <= 5; i++) bus_write(BASE, 8'(i));
      bus_write(BASE, 8'h06);
      check("burst_started", {31'd0, mon_active}, 32'd1);
      bus_read(STAT);
      wait_tx_drain();
      check("burst_frame_count", start_q.size(), 5);
      for (int i = 1; i < start_q.size(); i++)
         check("burst_gap", start_q[i] - start_q[i-1], 10 * CPB);
      bus_read(STAT);

      // Unmapped addresses are ignored and read as zero
      bus_write(8'h12, 8'h55);
      bus_read(8'h12);
      bus_read(8'h0F);
      idle(20);

      // RX with overrun
      send_rx(8'h3C, 1'b1);
      m_rx_done(8'h3C, 1'b1);
      send_rx(8'hC3, 1'b1);
      m_rx_done(8'hC3, 1'b1);
      idle(4);
      bus_read(STAT);
      bus_write(STAT, 8'hFF);
      bus_read(STAT);
      bus_read(BASE);
      bus_read(STAT);

      // Short glitch on rxd
      rxd = 1'b0;
      idle(8);
      rxd = 1'b1;
      idle(200);
      bus_read(STAT);

      // Framing error, then clear
      r1 = 8'($urandom);
      send_rx(r1, 1'b0);
      m_rx_done(r1, 1'b0);
      idle(4);
      bus_read(STAT);
      bus_write(STAT, 8'h00);
      bus_read(STAT);

      // DATA read coinciding with the stop-bit sample
      r1 = 8'($urandom);
      r2 = 8'($urandom);
      send_rx(r1, 1'b1);
      m_rx_done(r1, 1'b1);
      idle(4);
      fork
         send_rx(r2, 1'b1);
         begin
            idle(154);
            bus_read(BASE);
         end
      join
      m_rx_done(r2, 1'b1);
      idle(4);
      bus_read(STAT);
      bus_read(BASE);

      // STATUS write coinciding with a framing error
      r1 = 8'($urandom);
      fork
         send_rx(r1, 1'b0);
         begin
            idle(154);
            bus_write(STAT, 8'h00);
         end
      join
      m_rx_done(r1, 1'b0);
      idle(4);
      bus_read(STAT);
      bus_write(STAT, 8'h00);

      // Randomised mix of TX bursts and RX frames
      for (int it = 0; it < 8; it++) begin
         r1  = 8'($urandom);
         stp = ($urandom_range(0, 3) != 0);
         nk  = $urandom_range(1, 3);
         fork
            send_rx(r1, stp);
            for (int j = 0; j < nk; j++) begin
               idle($urandom_range(0, 20));
               bus_write(BASE, 8'($urandom));
            end
         join
         m_rx_done(r1, stp);
         wait_tx_drain();
         bus_read(STAT);
         if ($urandom_range(0, 1) == 1) bus_read(BASE);
         if ($urandom_range(0, 2) == 0) bus_write(STAT, 8'($urandom));
         idle(4);
      end

      // Reset in the middle of TX data bit 3
      r1 = 8'($urandom) & 8'hF7;
      bus_write(BASE, r1);
      idle(73);
      check("txd_bit3_before_reset", {31'd0, txd}, 32'd0);
      #2;
      rst = 1'b1;
      #1;
      check("txd_async_reset", {31'd0, txd}, 32'd1);
      tx_exp.delete();
      start_q.delete();
      m_hold  = 8'h00;
      m_valid = 0;
      m_ovr   = 0;
      m_ferr  = 0;
      m_busy  = 0;
      m_cnt   = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      low_cnt = txd_low_cnt;
      bus_read(STAT);
      bus_read(BASE);
      idle(300);
      check("txd_quiet_after_reset", txd_low_cnt - low_cnt, 0);
      check("no_frame_after_reset", start_q.size(), 0);
      check("read_queue_drained", rd_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/natalius_uart_port.md
NATALIUS_UART_PORT -- requirements
Module: natalius_uart_port

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 8'h10: port address of the DATA register; STATUS is at BASE_ADDR+1.
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16: clk cycles per UART bit, legal range 4 to 65535.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 port_addr  input  8  processor port address.
REQ-006 read_e  input  1  processor port read strobe, one cycle per access.
REQ-007 write_e  input  1  processor port write strobe, one cycle per access.
REQ-008 din  input  8  write data driven by the processor.
REQ-009 dout  output  8  read data returned to the processor.
REQ-010 rxd  input  1  asynchronous serial receive line.
REQ-011 txd  output  1  serial transmit line, idle high.

Function
REQ-012 dout SHALL be combinational and equal to:
- the RX holding register when read_e=1 and port_addr=BASE_ADDR;
- STATUS when read_e=1 and port_addr=BASE_ADDR+1;
- 8'h00 otherwise.
REQ-013 STATUS bit layout:
- [0] rx_valid
- [1] rx_overrun
- [2] rx_frame_err
- [3] tx_full
- [4] tx_empty
- [5] tx_busy
- [7:6] 0
REQ-014 A write_e at BASE_ADDR with the TX FIFO not full SHALL push din into a 4-entry TX FIFO; a write_e when full SHALL be discarded with no state change.
REQ-015 A write_e at BASE_ADDR+1 SHALL clear rx_overrun and rx_frame_err; din is ignored.
REQ-016 A read_e at BASE_ADDR SHALL clear rx_valid at that clock edge; STATUS reads SHALL have no side effects.
REQ-017 Accesses to any other address SHALL be ignored.
REQ-018 TX FSM states:
- IDLE, START, DATA, STOP.
- IDLE->START when the FIFO is non-empty: pop one entry in the same cycle.
- START drives 0 for CLKS_PER_BIT cycles.
- DATA drives bits 0..7, LSB first, each for CLKS_PER_BIT cycles.
- STOP drives 1 for CLKS_PER_BIT cycles, then returns to IDLE.
REQ-019 tx_busy SHALL be 1 in all TX states except IDLE.
REQ-020 Back-to-back frames SHALL have no idle gap: from STOP, go directly to START when the FIFO is non-empty.
REQ-021 FIFO full/empty SHALL use a 3-bit count, with wrap-around of 2-bit read and write pointers.
REQ-022 A push and a pop in the same cycle SHALL leave the count unchanged.
REQ-023 rxd SHALL pass through a 2-flop synchronizer before use.
REQ-024 RX FSM states:
- IDLE, START, DATA, STOP.
- IDLE->START on a synchronized falling edge.
- At CLKS_PER_BIT/2 (integer) cycles, if the line is high, return to IDLE (glitch); otherwise go to DATA.
- Sample each data bit every CLKS_PER_BIT cycles thereafter, LSB first.
- Sample the stop bit one further CLKS_PER_BIT later.
REQ-025 At the stop sample, with stop=1:
- if rx_valid=0: load the holding register and set rx_valid;
- if rx_valid=1: set rx_overrun and keep the old byte.
REQ-026 At the stop sample, with stop=0: set rx_frame_err and discard the byte.
REQ-027 The RX FSM SHALL return to IDLE immediately after the stop sample.
REQ-028 If a DATA read and a byte completion occur in the same cycle, the new byte SHALL be loaded, rx_valid SHALL remain 1, and no overrun SHALL be flagged.
REQ-029 If a STATUS write and an error event occur in the same cycle, the error set SHALL win.

Reset
REQ-030 On rst=1, asynchronously:
- txd=1;
- TX and RX FSMs in IDLE;
- FIFO count and pointers 0;
- rx_valid, rx_overrun and rx_frame_err 0;
- holding register 8'h00;
- bit counters and baud counters 0;
- synchronizer flops 1.
REQ-031 Reset asserted mid-frame SHALL abort the frame, drop all FIFO contents, and force txd high in the same cycle without waiting for a clock.
REQ-032 After reset release, STATUS SHALL read 8'h10.

Verification
REQ-033 Single TX byte: with CLKS_PER_BIT=16, write 8'hA5 to 8'h10 -> txd shows start, then 1,0,1,0,0,1,0,1, then stop, each bit 16 clocks; tx_busy=1 for 160 clocks; STATUS then reads 8'h10.
REQ-034 FIFO full: write 8'h01..8'h05 in five consecutive cycles while idle -> the first byte starts at once, STATUS bit3 is set after the fifth write, and 8'h01..8'h05 are transmitted back-to-back with no gaps.
REQ-035 RX with overrun: drive serial 8'h3C, then 8'hC3 without reading -> DATA reads 8'h3C, STATUS reads 8'h13 (includes tx_empty), and after a STATUS write bits 1:0 read 01 until DATA is read, after which they read 00.
REQ-036 RX glitch and framing error:
- An 8-clock low pulse on rxd -> no rx_valid.
- A frame with stop=0 -> rx_frame_err=1 and rx_valid=0.
REQ-037 Simultaneous events: DATA read coinciding with a stop-bit sample -> new byte present, rx_valid=1, rx_overrun=0.
REQ-038 Reset mid-frame: assert rst during DATA bit 3 of a TX frame -> txd=1 asynchronously; after release, STATUS reads 8'h10 and no further txd activity occurs.
